inst_fetch_ctrl: RTL
====================

// Module: inst_fetch_ctrl
// PURPOSE
//   Sequences the instruction ROM for the core front end. Owns the fetch PC and issues
//   word addresses to the synchronous inst ROM, which has 1-cycle read latency.
//   Returns {pc, inst} pairs to decode through a DEPTH-entry buffer with a valid/ready handshake.
//   Handles branch/jump redirects by flushing the buffer and discarding any read in flight.
// PARAMETERS
//   RESET_PC  32'h0000_0000  fetch PC loaded on reset
//   ADDR_W    14             ROM word-address width (14 normal build, 16 DEBUG build)
//   DEPTH     4              instruction buffer entries; power of 2, >= 2
// PORTS
//   clk            in   1       core clock, rising edge
//   rst_n          in   1       asynchronous active-low reset
//   redirect_valid in   1       load redirect_pc as the new fetch PC; flush
//   redirect_pc    in   32      redirect target; bits [1:0] ignored (forced 0)
//   mem_en         out  1       ROM read issued this cycle
//   mem_addr       out  ADDR_W  ROM word address = fetch_pc[ADDR_W+1:2]
//   mem_rdata      in   32      ROM data, valid the cycle after mem_en
//   inst_valid     out  1       buffer head valid
//   inst_ready     in   1       decode accepts head when inst_valid & inst_ready
//   inst_pc        out  32      PC of head instruction
//   inst_data      out  32      head instruction word
//   fetch_pc       out  32      current fetch PC register (debug/trace)
// BEHAVIOUR
//   Reset (async, rst_n=0) clears all state.
//   - fetch_pc=RESET_PC; FSM=BOOT; count=0; inflight=0.
//   - mem_en=0, inst_valid=0, inst_pc=0, inst_data=0.
//   FSM (registered):
//   - BOOT: one idle cycle after reset release; no issue. Goes to RUN,
//     or to REDIR if redirect_valid.
//   - RUN: issue when count+inflight < DEPTH (registered values; a same-cycle pop
//     is not credited). Otherwise move to HOLD with no issue.
//   - HOLD: no issue. Return to RUN once count+inflight < DEPTH, evaluated each cycle.
//   - REDIR: one-cycle bubble; no issue. Next state is RUN.
//   - redirect_valid in any state wins. That cycle:
//     - mem_en=0; fetch_pc<=redirect_pc&~3; FSM<=REDIR.
//     - Buffer flushed (count<=0); inst_valid is still driven from the pre-flush head
//       and a pop that cycle is legal.
//     - Any inflight read is killed; its mem_rdata next cycle is dropped.
//   Issue:
//   - mem_en=1 combinationally in RUN when credit is available and redirect_valid=0.
//   - mem_addr=fetch_pc[ADDR_W+1:2]; upper PC bits are truncated, no fault.
//   - On issue: fetch_pc<=fetch_pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
//     The issued PC is latched as the tag; inflight<=1.
//   - mem_addr holds fetch_pc[ADDR_W+1:2] when mem_en=0.
//   Return:
//   - The cycle after an unkilled issue, {tag, mem_rdata} is pushed at the tail.
//     inflight clears the same cycle unless a new issue occurs.
//   - Credit accounting guarantees the push never overflows. Push and pop in the
//     same cycle leave count unchanged.
//   Output: inst_valid = count!=0; inst_pc/inst_data = head entry, stable while valid & !ready.
//   Latency: issue at cycle N, push at edge N+1, earliest inst_valid at N+2.
//     Sustained 1 inst/cycle when inst_ready=1.
//   Empty buffer: no bypass of mem_rdata to outputs.
//   Pop on empty is ignored.
// TESTING
//   1. Reset release, RESET_PC=0, inst_ready=1
//      -> BOOT 1 cycle; mem_addr 0,1,2,...
//      -> inst_pc 0,4,8 on consecutive cycles from cycle 3.
//   2. inst_ready=0 for 10 cycles
//      -> exactly DEPTH(4) issues, then mem_en=0 (HOLD); head pc/data stable.
//      Release -> no drop, no duplicate.
//   3. redirect_valid, redirect_pc=32'h0000_0103, while a read is inflight and buffer=2
//      -> inflight data dropped; inst_valid=0 next cycle.
//      -> next issue mem_addr=0x40; next inst_pc=0x100.
//   4. fetch_pc=32'hFFFF_FFFC issue -> inst_pc FFFF_FFFC, then 0x0; mem_addr wraps to 0x3FFF then 0.
//   5. Pop while full (count=4) plus redirect in the same cycle
//      -> popped entry consumed once; buffer empty after; no push from killed read.
//   6. rst_n low mid-stream (async, between edges)
//      -> outputs 0 immediately; restart from RESET_PC after release.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: drives the 1-cycle-latency instruction ROM and queues {pc, inst} pairs for decode.
// Ports: clk/rst_n (async active-low), redirect_valid/redirect_pc (flush + new fetch PC),
// mem_en/mem_addr/mem_rdata (ROM), inst_valid/inst_ready/inst_pc/inst_data (decode handshake),
// fetch_pc (trace).
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 14,
  parameter int          DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_pc,
  output logic [31:0]       inst_data,
  output logic [31:0]       fetch_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LIM = CW'(DEPTH);
  typedef enum logic [1:0] {BOOT, RUN, HOLD, REDIR} state_t;
  state_t r_state, w_state_nxt;
  logic [31:0] r_fetch_pc, r_tag;
  logic [CW-1:0] r_count, w_occ;
  logic [PW-1:0] r_head, r_tail;
  logic r_inflight, w_credit, w_issue, w_push, w_pop;
  logic [31:0] r_pc_mem [DEPTH];
  logic [31:0] r_data_mem [DEPTH];
  logic [1:0] w_unused;
  assign w_unused = redirect_pc[1:0];
  // Credit uses registered occupancy only, so a pop this cycle frees space next cycle.
  always_comb begin
    w_occ = r_count + CW'(r_inflight);
    w_credit = w_occ < LIM;
    w_issue = (r_state == RUN) && w_credit && !redirect_valid;
    w_state_nxt = redirect_valid ? REDIR :
                  (r_state == BOOT || r_state == REDIR || w_credit) ? RUN : HOLD;
  end
  // A read in flight during a redirect returns stale data, so it is never pushed.
  assign w_push = r_inflight && !redirect_valid;
  assign w_pop = inst_ready && (r_count != '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_fetch_pc <= RESET_PC;
      r_tag <= '0;
      r_inflight <= 1'b0;
      r_count <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_inflight <= w_issue;
      if (redirect_valid) r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_issue) r_tag <= r_fetch_pc;
      r_count <= redirect_valid ? '0 : r_count + CW'(w_push) - CW'(w_pop);
      r_head <= redirect_valid ? '0 : r_head + PW'(w_pop);
      r_tail <= redirect_valid ? '0 : r_tail + PW'(w_push);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail] <= r_tag;
      r_data_mem[r_tail] <= mem_rdata;
    end
  end
  assign mem_en = w_issue;
  assign mem_addr = r_fetch_pc[ADDR_W+1:2];
  assign inst_valid = r_count != '0;
  // Gating keeps the head outputs at zero whenever the buffer is empty, including reset.
  assign inst_pc = inst_valid ? r_pc_mem[r_head] : '0;
  assign inst_data = inst_valid ? r_data_mem[r_head] : '0;
  assign fetch_pc = r_fetch_pc;
endmodule
